// File: rtl/ama_riscv_defines.sv
// rtl/ama_riscv_defines.sv - shared immediate-format select codes for decoder and imm gen
package ama_riscv_defines;

  localparam logic [2:0] IG_DISABLED = 3'b000;
  localparam logic [2:0] IG_I_TYPE   = 3'b001;
  localparam logic [2:0] IG_S_TYPE   = 3'b010;
  localparam logic [2:0] IG_B_TYPE   = 3'b011;
  localparam logic [2:0] IG_J_TYPE   = 3'b100;
  localparam logic [2:0] IG_U_TYPE   = 3'b101;

endpackage

// File: rtl/ama_riscv_imm_gen_dec.sv
// rtl/ama_riscv_imm_gen_dec.sv - combinational immediate decode; option IMM_GEN_INVALID_ZERO_EN
module ama_riscv_imm_gen_dec
  import ama_riscv_defines::*;
(
  input  logic [2:0]  ig_sel,
  input  logic [31:7] ig_in,
  output logic [31:0] next_imm,
  output logic        load,
  output logic        clear
);

  // Assemble the immediate for the selected format; load only for valid formats
  always_comb begin
    next_imm = 32'h0;
    load     = 1'b0;
    clear    = 1'b0;
    case (ig_sel)
      IG_I_TYPE: begin
        next_imm = {{20{ig_in[31]}}, ig_in[31:20]};
        load     = 1'b1;
      end
      IG_S_TYPE: begin
        next_imm = {{20{ig_in[31]}}, ig_in[31:25], ig_in[11:7]};
        load     = 1'b1;
      end
      IG_B_TYPE: begin
        next_imm = {{19{ig_in[31]}}, ig_in[31], ig_in[7], ig_in[30:25], ig_in[11:8], 1'b0};
        load     = 1'b1;
      end
      IG_J_TYPE: begin
        next_imm = {{11{ig_in[31]}}, ig_in[31], ig_in[19:12], ig_in[20], ig_in[30:21], 1'b0};
        load     = 1'b1;
      end
      IG_U_TYPE: begin
        next_imm = {ig_in[31:12], 12'h000};
        load     = 1'b1;
      end
      IG_DISABLED: begin
        load = 1'b0;
      end
      default: begin
`ifdef IMM_GEN_INVALID_ZERO_EN
        clear = 1'b1;
`else
        clear = 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/ama_riscv_imm_gen.sv
// rtl/ama_riscv_imm_gen.sv - registered RV32I immediate generator; option IMM_GEN_INVALID_ZERO_EN
module ama_riscv_imm_gen
  import ama_riscv_defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ig_sel,
  input  logic [31:7] ig_in,
  output logic [31:0] ig_out
);

  logic [31:0] next_imm;
  logic        load;
  logic        clear;

  ama_riscv_imm_gen_dec u_dec (
    .ig_sel   (ig_sel),
    .ig_in    (ig_in),
    .next_imm (next_imm),
    .load     (load),
    .clear    (clear)
  );

  // Output register: reset wins, then clear of invalid codes, then load; otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      ig_out <= 32'h0;
    end else if (clear) begin
      ig_out <= 32'h0;
    end else if (load) begin
      ig_out <= next_imm;
    end
  end

endmodule

// File: tb/tb_ama_riscv_imm_gen.sv
// tb/tb_ama_riscv_imm_gen.sv - vector-table and random-model bench for the immediate generator
module tb_ama_riscv_imm_gen;

  typedef struct {
    logic        r;
    logic [2:0]  sel;
    logic [31:0] ins;
    logic [31:0] exp;
  } vec_t;

`ifdef IMM_GEN_INVALID_ZERO_EN
  localparam logic [31:0] INV_AFTER_7FF = 32'h0000_0000;
`else
  localparam logic [31:0] INV_AFTER_7FF = 32'h0000_07FF;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  ig_sel = 3'b000;
  logic [31:0] instr = 32'h0;
  logic [31:7] ig_in;
  logic [31:0] ig_out;

  int n_vec = 0;
  int n_err = 0;

  vec_t vecs[$];

  assign ig_in = instr[31:7];

  ama_riscv_imm_gen dut (
    .clk    (clk),
    .rst    (rst),
    .ig_sel (ig_sel),
    .ig_in  (ig_in),
    .ig_out (ig_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] exp);
    n_vec++;
    if (ig_out !== exp) begin
      n_err++;
      $display("FAIL %s: ig_out=%h expected %h", name, ig_out, exp);
    end
  endtask

  task automatic apply(input logic r, input logic [2:0] s, input logic [31:0] ins,
                       input logic [31:0] exp, input string name);
    @(negedge clk);
    rst    = r;
    ig_sel = s;
    instr  = ins;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  function automatic logic [31:0] model(input logic [31:0] cur, input logic r,
                                        input logic [2:0] s, input logic [31:0] i);
    logic [31:0] v;
    v = cur;
    if (r) return 32'h0;
    case (s)
      3'd1: v = 32'($signed(i) >>> 20);
      3'd2: v = (32'($signed(i) >>> 20) & ~32'h1F) | 32'((i >> 7) & 32'h1F);
      3'd3: begin
        v = 32'($signed(i) >>> 19) & 32'hFFFF_F000;
        v = v | (32'((i >> 7) & 32'h1) << 11) | (32'((i >> 25) & 32'h3F) << 5)
              | (32'((i >> 8) & 32'hF) << 1);
      end
      3'd4: begin
        v = 32'($signed(i) >>> 11) & 32'hFFF0_0000;
        v = v | (i & 32'h000F_F000) | (32'((i >> 20) & 32'h1) << 11)
              | (32'((i >> 21) & 32'h3FF) << 1);
      end
      3'd5: v = i & 32'hFFFF_F000;
      3'd0: v = cur;
      default: begin
`ifdef IMM_GEN_INVALID_ZERO_EN
        v = 32'h0;
`else
        v = cur;
`endif
      end
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] m;
    logic        r;
    logic [2:0]  s;
    logic [31:0] i;

    vecs.push_back('{1'b1, 3'd0, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{1'b1, 3'd1, 32'hFFF0_0000, 32'h0000_0000});
    vecs.push_back('{1'b1, 3'd5, 32'h1234_5000, 32'h0000_0000});
    vecs.push_back('{1'b0, 3'd0, 32'hDEAD_BEEF, 32'h0000_0000});
    vecs.push_back('{1'b0, 3'd1, 32'hFFF0_0000, 32'hFFFF_FFFF});
    vecs.push_back('{1'b0, 3'd1, 32'h7FF0_0000, 32'h0000_07FF});
    vecs.push_back('{1'b0, 3'd2, 32'hFE00_0F80, 32'hFFFF_FFFF});
    vecs.push_back('{1'b0, 3'd3, 32'hFE00_0F80, 32'hFFFF_FFFE});
    vecs.push_back('{1'b0, 3'd4, 32'hFFFF_F000, 32'hFFFF_FFFE});
    vecs.push_back('{1'b0, 3'd5, 32'hFFFF_F000, 32'hFFFF_F000});
    vecs.push_back('{1'b0, 3'd5, 32'h1234_5000, 32'h1234_5000});
    vecs.push_back('{1'b0, 3'd2, 32'h0000_0080, 32'h0000_0001});
    vecs.push_back('{1'b0, 3'd3, 32'h8000_0080, 32'hFFFF_F800});
    vecs.push_back('{1'b0, 3'd4, 32'h0010_0000, 32'h0000_0800});
    vecs.push_back('{1'b0, 3'd1, 32'h7FF0_0000, 32'h0000_07FF});
    vecs.push_back('{1'b0, 3'd0, 32'hA5A5_A5A5, 32'h0000_07FF});
    vecs.push_back('{1'b0, 3'd0, 32'h5A5A_5A5A, 32'h0000_07FF});
    vecs.push_back('{1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0000_07FF});
    vecs.push_back('{1'b0, 3'd6, 32'hFFFF_FFFF, INV_AFTER_7FF});
    vecs.push_back('{1'b0, 3'd7, 32'h1234_5000, INV_AFTER_7FF});
    vecs.push_back('{1'b1, 3'd1, 32'hFFF0_0000, 32'h0000_0000});
    vecs.push_back('{1'b0, 3'd6, 32'hFFF0_0000, 32'h0000_0000});
    vecs.push_back('{1'b0, 3'd5, 32'h1234_5000, 32'h1234_5000});

    foreach (vecs[k]) begin
      apply(vecs[k].r, vecs[k].sel, vecs[k].ins, vecs[k].exp, $sformatf("vec%0d", k));
    end

    // Output must not follow inputs before the next edge
    apply(1'b0, 3'd1, 32'h0010_0000, 32'h0000_0001, "lat_load");
    @(negedge clk);
    ig_sel = 3'd5;
    instr  = 32'hABCD_E000;
    #1;
    check("lat_no_comb", 32'h0000_0001);
    @(posedge clk);
    #1;
    check("lat_next_edge", 32'hABCD_E000);

    // Random sequence against the reference model, reset forced partway through
    m = 32'hABCD_E000;
    for (int c = 0; c < 96; c++) begin
      r = (c == 40) || ($urandom_range(0, 15) == 0);
      s = 3'($urandom_range(0, 7));
      i = $urandom;
      m = model(m, r, s, i);
      apply(r, s, i, m, $sformatf("rand%0d_sel%0d_rst%0d", c, s, r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ama_riscv_imm_gen.md
Name: ama_riscv_imm_gen

Overview:
Immediate generator for the AMA-RISCV decode stage. It takes instruction bits [31:7] and an immediate-format select from the control decoder. It produces the sign-extended 32-bit immediate for I/S/B/J types, or the upper immediate for U type. The output is registered: one clock of latency, and it holds its value when disabled.

Parameters:
None. Widths are fixed by the RV32I ISA.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ig_sel  in  3  immediate format select (codes below).
- ig_in  in  25  instruction bits [31:7]; port index range is [31:7], so bit numbers match the instruction word.
- ig_out  out  32  registered immediate.

Behaviour:
- Select codes: IG_DISABLED=3'b000, IG_I_TYPE=3'b001, IG_S_TYPE=3'b010, IG_B_TYPE=3'b011, IG_J_TYPE=3'b100, IG_U_TYPE=3'b101. Codes 3'b110 and 3'b111 are invalid.
- Reset: when rst=1 at a rising edge, ig_out <= 32'h0. rst has priority over every ig_sel value.
- Latency: ig_out reflects the ig_sel/ig_in values sampled at the most recent rising edge. There is no combinational path from input to output.
- I type: ig_out = sign-extend(ig_in[31:20]), 12-bit source.
- S type: ig_out = sign-extend({ig_in[31:25], ig_in[11:7]}), 12-bit source.
- B type: ig_out = sign-extend({ig_in[31], ig_in[7], ig_in[30:25], ig_in[11:8], 1'b0}), 13-bit source; bit 0 is always 0.
- J type: ig_out = sign-extend({ig_in[31], ig_in[19:12], ig_in[20], ig_in[30:21], 1'b0}), 21-bit source; bit 0 is always 0.
- U type: ig_out = {ig_in[31:12], 12'h000}; no extension needed.
- Sign bit: ig_in[31] for every sign-extended type.
- IG_DISABLED: ig_out keeps its previous value (register enable deasserted).
- Invalid codes (110, 111): ig_out keeps its previous value, same as disabled (default build).
- Back-to-back selects: each cycle is independent. A format change takes effect on the very next edge, with no bubble.
- Reset released mid-stream: the first non-reset edge loads the selected immediate, or holds 0 if disabled or invalid.

Optional Feature:
IMM_GEN_INVALID_ZERO_EN
- Defined: invalid codes 110/111 load ig_out <= 32'h0 at the edge. IG_DISABLED still holds.
- Undefined (default): invalid codes hold the previous ig_out.
- In both builds, valid codes and reset behave identically.

Decomposition:
- Shared package ama_riscv_defines: the IG_* select constants, shared with the control decoder.
- One natural sub-module, ama_riscv_imm_gen_dec: purely combinational. Maps ig_sel/ig_in to next_imm plus a load/clear indication.
- The top module contains only the output register with its reset, enable and optional clear logic.

Test Plan:
1. Reset: rst=1 for 3 cycles -> ig_out=32'h0. Then ig_sel=000 -> ig_out stays 32'h0.
2. I type with instr=32'hFFF00000 -> FFFFFFFF. I type with instr=32'h7FF00000 -> 000007FF one cycle later.
3. S type with instr=32'hFE000F80 -> FFFFFFFF. B type with the same instr -> FFFFFFFE.
4. J type with instr=32'hFFFFF000 -> FFFFFFFE. U type with the same instr -> FFFFF000. U type with instr=32'h12345000 -> 12345000.
5. Hold: load 32'h000007FF, then apply sel=000 with a random ig_in for 3 cycles -> ig_out stays 000007FF.
   - Default build, sel=110/111 -> ig_out stays 000007FF.
   - IMM_GEN_INVALID_ZERO_EN build, sel=110/111 -> ig_out = 0.
6. Random: 64+ cycles of random ig_sel (0..7) and random instructions, compared each cycle against a reference model of the rules above. Include rst asserted mid-sequence -> ig_out = 0 on that edge.
